// File: rtl/mips_cpu_pc_seq.sv
// Program-counter sequencer: sequential fetch, branch/jump/jr redirects,
// optional branch delay slot, misaligned-JR exception redirect, halt detect.
module mips_cpu_pc_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          DELAY_SLOT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_ctrl,
    input  logic        branch_taken,
    input  logic [31:0] instr,
    input  logic [31:0] reg_readdata,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus8,
    output logic [31:0] epc,
    output logic        exc,
    output logic        active
);

    typedef enum logic [1:0] {RUN, DELAY, HALTED} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_pend, r_epc;
    logic        r_pexc, r_exc;

    logic [31:0] w_p4, w_br, w_jmp, w_tgt;
    logic [31:0] w_pc_nxt, w_pend_nxt, w_epc_nxt;
    logic        w_pexc_nxt, w_exc_nxt;
    logic        w_bad, w_redir;

    assign w_p4    = r_pc + 32'd4;
    assign w_br    = w_p4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_jmp   = {w_p4[31:28], instr[25:0], 2'b00};
    assign w_bad   = (pc_ctrl == 2'd3) && (reg_readdata[1:0] != 2'b00);
    assign w_redir = ((pc_ctrl == 2'd1) && branch_taken) || pc_ctrl[1];

    always_comb begin
        w_tgt = w_p4;
        unique case (pc_ctrl)
            2'd1:    w_tgt = w_br;
            2'd2:    w_tgt = w_jmp;
            2'd3:    w_tgt = w_bad ? EXC_VECTOR : reg_readdata;
            default: w_tgt = w_p4;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_pexc_nxt  = r_pexc;
        w_epc_nxt   = r_epc;
        w_exc_nxt   = 1'b0;
        unique case (r_state)
            RUN: begin
                w_pc_nxt = w_p4;
                if (w_redir) begin
                    if (w_bad)
                        w_epc_nxt = r_pc;
                    if (DELAY_SLOT != 0) begin
                        w_pend_nxt  = w_tgt;
                        w_pexc_nxt  = w_bad;
                        w_state_nxt = DELAY;
                    end else begin
                        w_pc_nxt  = w_tgt;
                        w_exc_nxt = w_bad;
                    end
                end
            end
            DELAY: begin
                w_pc_nxt    = r_pend;
                w_exc_nxt   = r_pexc;
                w_state_nxt = RUN;
            end
            default: ;
        endcase
        // Halt is judged on the address being loaded, whatever its source.
        if (r_state != HALTED && w_pc_nxt == HALT_ADDR)
            w_state_nxt = HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_VECTOR;
            r_pend  <= 32'd0;
            r_pexc  <= 1'b0;
            r_epc   <= 32'd0;
            r_exc   <= 1'b0;
        end else if (stall) begin
            r_exc <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_pexc  <= w_pexc_nxt;
            r_epc   <= w_epc_nxt;
            r_exc   <= w_exc_nxt;
        end
    end

    assign pc_out   = r_pc;
    assign pc_plus8 = r_pc + 32'd8;
    assign epc      = r_epc;
    assign exc      = r_exc;
    assign active   = (r_state != HALTED);

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Bench for mips_cpu_pc_seq: delay-slot and no-delay-slot instances checked
// every cycle against a behavioural model, plus hand-computed fetch addresses.
module tb_mips_cpu_pc_seq;

    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] HA  = 32'h00000000;
    localparam logic [31:0] EV  = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_ctrl = 2'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] reg_readdata = 32'd0;

    logic [31:0] pc1, p81, epc1, pc0, p80, epc0;
    logic        exc1, act1, exc0, act0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mips_cpu_pc_seq #(.DELAY_SLOT(1)) u_ds1 (
        .clk(clk), .rst(rst), .stall(stall), .pc_ctrl(pc_ctrl),
        .branch_taken(branch_taken), .instr(instr),
        .reg_readdata(reg_readdata), .pc_out(pc1), .pc_plus8(p81),
        .epc(epc1), .exc(exc1), .active(act1)
    );

    mips_cpu_pc_seq #(.DELAY_SLOT(0)) u_ds0 (
        .clk(clk), .rst(rst), .stall(stall), .pc_ctrl(pc_ctrl),
        .branch_taken(branch_taken), .instr(instr),
        .reg_readdata(reg_readdata), .pc_out(pc0), .pc_plus8(p80),
        .epc(epc0), .exc(exc0), .active(act0)
    );

    // Architectural view: the address being fetched, an optional queued
    // redirect that lands after one more fetch, and a halted flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] queued;
        bit          has_q;
        bit          q_exc;
        logic [31:0] epc;
        bit          exc;
        bit          halted;
    } mst_t;

    mst_t m1, m0;

    function automatic mst_t mstep(mst_t s, bit ds);
        mst_t        n;
        logic [31:0] tgt;
        logic [31:0] off;
        bit          go;
        bit          bad;
        n = s;
        n.exc = 1'b0;
        if (rst) begin
            n.pc = RV; n.queued = 0; n.has_q = 0; n.q_exc = 0;
            n.epc = 0; n.halted = 0;
            return n;
        end
        if (stall || s.halted)
            return n;
        if (s.has_q) begin
            n.pc = s.queued; n.exc = s.q_exc; n.has_q = 0;
        end else begin
            off = 32'(signed'(instr[15:0])) * 4;
            bad = 0;
            go  = 1;
            case (pc_ctrl)
                2'd1: begin tgt = s.pc + 4 + off; go = branch_taken; end
                2'd2: tgt = ((s.pc + 4) & 32'hF000_0000) | (instr[25:0] * 4);
                2'd3: begin
                    bad = (reg_readdata % 4) != 0;
                    tgt = bad ? EV : reg_readdata;
                end
                default: begin tgt = s.pc + 4; go = 0; end
            endcase
            if (bad) n.epc = s.pc;
            if (go && ds) begin
                n.pc = s.pc + 4; n.queued = tgt; n.has_q = 1; n.q_exc = bad;
            end else if (go) begin
                n.pc = tgt; n.exc = bad;
            end else begin
                n.pc = s.pc + 4;
            end
        end
        if (n.pc == HA) begin n.halted = 1; n.has_q = 0; end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 = mstep(m1, 1'b1);
        m0 = mstep(m0, 1'b0);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m1.pc", pc1, m1.pc);
            chk("m1.pc8", p81, m1.pc + 8);
            chk("m1.epc", epc1, m1.epc);
            chk("m1.exc", {31'd0, exc1}, {31'd0, m1.exc});
            chk("m1.act", {31'd0, act1}, {31'd0, !m1.halted});
            chk("m0.pc", pc0, m0.pc);
            chk("m0.pc8", p80, m0.pc + 8);
            chk("m0.epc", epc0, m0.epc);
            chk("m0.exc", {31'd0, exc0}, {31'd0, m0.exc});
            chk("m0.act", {31'd0, act0}, {31'd0, !m0.halted});
        end
    end

    task automatic drv(input logic [1:0] c, input logic t,
                       input logic [31:0] ins, input logic [31:0] rd,
                       input logic s, input logic r);
        pc_ctrl = c; branch_taken = t; instr = ins;
        reg_readdata = rd; stall = s; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic sq();
        drv(2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_rst();
        drv(2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    initial begin
        do_rst();
        chk_en = 1'b1;
        chk("rst.pc1", pc1, 32'hBFC00000);
        chk("rst.pc0", pc0, 32'hBFC00000);
        chk("rst.act", {31'd0, act1}, 32'd1);
        chk("rst.exc", {31'd0, exc1}, 32'd0);
        chk("rst.epc", epc1, 32'd0);
        chk("rst.pc8", p81, 32'hBFC00008);
        sq();
        chk("seq1", pc1, 32'hBFC00004);
        sq();
        chk("seq2", pc1, 32'hBFC00008);
        drv(2'd1, 1'b0, 32'h0000FFFC, 32'd0, 1'b0, 1'b0);
        chk("bnt", pc1, 32'hBFC0000C);
        sq();
        chk("seq4", pc1, 32'hBFC00010);
        drv(2'd1, 1'b1, 32'h0000FFFC, 32'd0, 1'b0, 1'b0);
        chk("br.slot", pc1, 32'hBFC00014);
        chk("br.ds0", pc0, 32'hBFC00004);
        sq();
        chk("br.tgt", pc1, 32'hBFC00004);
        repeat (7) sq();
        chk("at20", pc1, 32'hBFC00020);
        drv(2'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("jr0.slot", pc1, 32'hBFC00024);
        chk("jr0.act", {31'd0, act1}, 32'd1);
        chk("jr0.ds0", pc0, 32'h00000000);
        chk("jr0.ds0act", {31'd0, act0}, 32'd0);
        sq();
        chk("halt.pc", pc1, 32'h00000000);
        chk("halt.act", {31'd0, act1}, 32'd0);
        repeat (2) drv(2'd2, 1'b0, 32'h08000100, 32'd0, 1'b0, 1'b0);
        chk("halt.hold", pc1, 32'h00000000);
        do_rst();
        chk("rst2", pc1, 32'hBFC00000);
        chk("rst2.act", {31'd0, act1}, 32'd1);
        repeat (12) sq();
        chk("at30", pc1, 32'hBFC00030);
        drv(2'd3, 1'b0, 32'd0, 32'h00400002, 1'b0, 1'b0);
        chk("jrx.slot", pc1, 32'hBFC00034);
        chk("jrx.exc0", {31'd0, exc1}, 32'd0);
        chk("jrx.ds0", pc0, 32'hBFC00380);
        chk("jrx.ds0exc", {31'd0, exc0}, 32'd1);
        sq();
        chk("jrx.pc", pc1, 32'hBFC00380);
        chk("jrx.exc", {31'd0, exc1}, 32'd1);
        chk("jrx.epc", epc1, 32'hBFC00030);
        sq();
        chk("jrx.pulse", {31'd0, exc1}, 32'd0);
        chk("jrx.next", pc1, 32'hBFC00384);
        drv(2'd1, 1'b1, 32'h00000004, 32'd0, 1'b0, 1'b0);
        chk("d.slot", pc1, 32'hBFC00388);
        repeat (3) drv(2'd2, 1'b0, 32'h08000100, 32'd0, 1'b1, 1'b0);
        chk("stall.pc", pc1, 32'hBFC00388);
        chk("stall.ds0", pc0, 32'hBFC0039C);
        drv(2'd2, 1'b0, 32'h08000100, 32'd0, 1'b0, 1'b0);
        chk("slot.ign", pc1, 32'hBFC00398);
        chk("j.ds0", pc0, 32'hB0000400);
        sq();
        chk("after.slot", pc1, 32'hBFC0039C);
        drv(2'd1, 1'b1, 32'h00000004, 32'd0, 1'b0, 1'b0);
        chk("d2.slot", pc1, 32'hBFC003A0);
        do_rst();
        chk("rstd.pc", pc1, 32'hBFC00000);
        sq();
        chk("rstd.seq", pc1, 32'hBFC00004);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
